// File: rtl/ssd_image_accumulator_if.sv
// Read-only bus from the SSD accumulator to the two image RAMs (A and B share one address).
interface ssd_image_accumulator_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_cs;
  logic              mem_clken;
  logic [DATA_W-1:0] readdata_a;
  logic [DATA_W-1:0] readdata_b;

  modport master (
    output mem_address, mem_cs, mem_clken,
    input  readdata_a, readdata_b
  );

  modport slave (
    input  mem_address, mem_cs, mem_clken,
    output readdata_a, readdata_b
  );
endinterface

// File: rtl/ssd_image_accumulator.sv
// Scans pixels 0..len-1 of image RAMs A and B in lockstep and accumulates
// the sum of squared differences through a 3-stage diff/square/add pipeline.
module ssd_image_accumulator #(
  parameter int NUM_PIXELS = 58368,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int ACC_W      = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      len,
  input  logic                   abort,
  ssd_image_accumulator_if.master ram,
  output logic                   busy,
  output logic                   done,
  output logic [ACC_W-1:0]       result
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(NUM_PIXELS);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                rd_vld_q, rd_vld_d;
  logic                d1_vld_q, d1_vld_d;
  logic                sq_vld_q, sq_vld_d;
  logic [DATA_W-1:0]   diff_q, diff_d;
  logic [2*DATA_W-1:0] sq_q, sq_d;

  logic [ADDR_W-1:0]   len_c;
  logic [DATA_W:0]     sub;

  assign ram.mem_address = addr_q;
  assign ram.mem_cs      = (state_q == READ);
  assign ram.mem_clken   = (state_q == READ);
  assign busy            = busy_q;
  assign done            = done_q;
  assign result          = result_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    acc_d    = acc_q;

    len_c = (len > MAX_N) ? MAX_N : len;

    // Pipeline advances unconditionally; the valid bits decide what counts.
    sub      = {1'b0, ram.readdata_a} - {1'b0, ram.readdata_b};
    diff_d   = sub[DATA_W] ? (~sub[DATA_W-1:0] + DATA_W'(1)) : sub[DATA_W-1:0];
    rd_vld_d = (state_q == READ);
    d1_vld_d = rd_vld_q;
    sq_d     = (2*DATA_W)'(diff_q) * (2*DATA_W)'(diff_q);
    sq_vld_d = d1_vld_q;
    if (sq_vld_q) acc_d = acc_q + ACC_W'(sq_q);

    unique case (state_q)
      IDLE: begin
        // busy while IDLE marks an accepted zero-length scan awaiting its done pulse
        if (busy_q) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = '0;
        end else if (start) begin
          busy_d = 1'b1;
          acc_d  = '0;
          addr_d = '0;
          if (len_c != '0) begin
            last_d  = len_c - ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      READ: begin
        if (addr_q == last_q) state_d = DRAIN;
        else                  addr_d  = addr_q + ADDR_W'(1);
      end
      DRAIN: begin
        if (sq_vld_q && !d1_vld_q && !rd_vld_q) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_q + ACC_W'(sq_q);
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over completion in the same cycle.
    if (abort && busy_q) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
      rd_vld_d = 1'b0;
      d1_vld_d = 1'b0;
      sq_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      last_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      rd_vld_q <= 1'b0;
      d1_vld_q <= 1'b0;
      sq_vld_q <= 1'b0;
      diff_q   <= '0;
      sq_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      rd_vld_q <= rd_vld_d;
      d1_vld_q <= d1_vld_d;
      sq_vld_q <= sq_vld_d;
      diff_q   <= diff_d;
      sq_q     <= sq_d;
    end
  end

endmodule

// File: tb/tb_ssd_image_accumulator.sv
// Directed bench for ssd_image_accumulator with a 1-cycle-latency RAM model.
module tb_ssd_image_accumulator;

  localparam int NPIX = 58368;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [31:0] result;

  ssd_image_accumulator_if #(.ADDR_W(16), .DATA_W(8)) ram_if ();

  ssd_image_accumulator #(
    .NUM_PIXELS(NPIX),
    .ADDR_W(16),
    .DATA_W(8),
    .ACC_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .len(len),
    .abort(abort),
    .ram(ram_if.master),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_a [NPIX];
  logic [7:0] mem_b [NPIX];

  always @(posedge clk) begin
    if (ram_if.mem_cs && ram_if.mem_clken && int'(ram_if.mem_address) < NPIX) begin
      ram_if.readdata_a <= mem_a[int'(ram_if.mem_address)];
      ram_if.readdata_b <= mem_b[int'(ram_if.mem_address)];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_test1();
    for (int i = 0; i < NPIX; i++) begin
      mem_a[i] = 8'd0;
      mem_b[i] = 8'd0;
    end
    mem_a[0] = 8'd10; mem_b[0] = 8'd13;
    mem_a[1] = 8'd20; mem_b[1] = 8'd20;
    mem_a[2] = 8'd30; mem_b[2] = 8'd25;
    mem_a[3] = 8'd40; mem_b[3] = 8'd50;
  endtask

  int done_edge, busy_cyc, n_addr, last_addr, done_cnt;
  bit addr_ok;

  // Cycle c is the cycle after edge E(c); E0 is the edge that samples start.
  task automatic run_scan(input logic [15:0] l, input int budget, input int abort_at,
                          input bit restarts, input int reset_at);
    done_edge = -1; busy_cyc = 0; n_addr = 0; last_addr = -1; done_cnt = 0; addr_ok = 1;
    @(negedge clk);
    start = 1'b1;
    len   = l;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (ram_if.mem_cs) begin
        if (ram_if.mem_address != n_addr[15:0]) addr_ok = 0;
        if (!ram_if.mem_clken) addr_ok = 0;
        last_addr = int'(ram_if.mem_address);
        n_addr++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = c;
      end
      abort = (c == abort_at);
      start = restarts && (c % 7 == 3) && (c < 90);
      if (start) len = 16'd4;
      if (c == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_mid_addr",  32'(ram_if.mem_address), 32'd0);
        check("rst_mid_cs",    32'(ram_if.mem_cs), 32'd0);
        check("rst_mid_clken", 32'(ram_if.mem_clken), 32'd0);
        check("rst_mid_busy",  32'(busy), 32'd0);
        check("rst_mid_done",  32'(done), 32'd0);
        check("rst_mid_result", result, 32'd0);
        break;
      end
      if (done_edge >= 0 && c >= done_edge + 3) break;
      if (abort_at >= 0 && c >= abort_at + 4) break;
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;
    ram_if.readdata_a = '0;
    ram_if.readdata_b = '0;
    fill_test1();
    repeat (2) @(negedge clk);
    check("reset_addr",   32'(ram_if.mem_address), 32'd0);
    check("reset_cs",     32'(ram_if.mem_cs), 32'd0);
    check("reset_clken",  32'(ram_if.mem_clken), 32'd0);
    check("reset_busy",   32'(busy), 32'd0);
    check("reset_done",   32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b0;

    // len=4 basic scan
    run_scan(16'd4, 40, -1, 0, -1);
    check("t1_result",    result, 32'd134);
    check("t1_done_edge", 32'(done_edge), 32'd7);
    check("t1_busy_cyc",  32'(busy_cyc), 32'd7);
    check("t1_n_addr",    32'(n_addr), 32'd4);
    check("t1_addr_seq",  32'(addr_ok), 32'd1);
    check("t1_done_cnt",  32'(done_cnt), 32'd1);

    // zero-length scan
    run_scan(16'd0, 20, -1, 0, -1);
    check("t3_done_edge", 32'(done_edge), 32'd1);
    check("t3_result",    result, 32'd0);
    check("t3_no_cs",     32'(n_addr), 32'd0);
    check("t3_busy_cyc",  32'(busy_cyc), 32'd1);
    check("t3_done_cnt",  32'(done_cnt), 32'd1);

    // full image, over-long len clamped to NPIX
    for (int i = 0; i < NPIX; i++) begin
      mem_a[i] = 8'd255;
      mem_b[i] = 8'd0;
    end
    run_scan(16'd60000, NPIX + 40, -1, 0, -1);
    check("t2_result",    result, 32'd3795379200);
    check("t2_n_addr",    32'(n_addr), 32'd58368);
    check("t2_last_addr", 32'(last_addr), 32'd58367);
    check("t2_done_edge", 32'(done_edge), 32'd58371);
    check("t2_addr_seq",  32'(addr_ok), 32'd1);

    // repeated start while busy, identical images
    for (int i = 0; i < NPIX; i++) begin
      mem_a[i] = 8'(i * 7);
      mem_b[i] = 8'(i * 7);
    end
    run_scan(16'd100, 200, -1, 1, -1);
    check("t4_result",    result, 32'd0);
    check("t4_done_cnt",  32'(done_cnt), 32'd1);
    check("t4_done_edge", 32'(done_edge), 32'd103);
    check("t4_n_addr",    32'(n_addr), 32'd100);
    check("t4_addr_seq",  32'(addr_ok), 32'd1);

    // completed scan, aborted scan, then a fresh scan
    fill_test1();
    mem_a[60] = 8'd200;
    run_scan(16'd4, 40, -1, 0, -1);
    check("t5_first_result", result, 32'd134);
    run_scan(16'd100, 200, 50, 0, -1);
    check("t5_abort_done_cnt", 32'(done_cnt), 32'd0);
    check("t5_abort_busy_cyc", 32'(busy_cyc), 32'd51);
    check("t5_abort_n_addr",   32'(n_addr), 32'd51);
    check("t5_abort_result",   result, 32'd134);
    check("t5_abort_busy_low", 32'(busy), 32'd0);
    mem_b[1] = 8'd22;
    run_scan(16'd4, 40, -1, 0, -1);
    check("t5_restart_result",    result, 32'd138);
    check("t5_restart_done_edge", 32'(done_edge), 32'd7);

    // asynchronous reset mid-scan, then a clean scan
    mem_b[1] = 8'd20;
    run_scan(16'd100, 200, -1, 0, 20);
    @(negedge clk);
    reset = 1'b0;
    run_scan(16'd4, 40, -1, 0, -1);
    check("t6_result",    result, 32'd134);
    check("t6_done_edge", 32'(done_edge), 32'd7);
    check("t6_done_cnt",  32'(done_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
